// File: rtl/ahb2_pkg.sv
// Shared AMBA2 AHB encodings and bus width defaults used by the AHB2-to-APB bridge.
package ahb2_pkg;

    localparam int AHB2_ADDR_WIDTH = 32;
    localparam int AHB2_DATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/ahb2_apb_bridge.sv
// Single-slave AHB2 to APB bridge: each accepted AHB transfer becomes one APB SETUP/ACCESS
// transaction, with AHB wait states until completion and a two-cycle ERROR response on failure.
module ahb2_apb_bridge
    import ahb2_pkg::*;
#(
    parameter int ADDR_WIDTH = AHB2_ADDR_WIDTH,
    parameter int DATA_WIDTH = AHB2_DATA_WIDTH
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [1:0]            hresp,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic sampling;
    logic active_trans;
    logic accept;

    // Only states that drive hreadyout high may take a new address phase.
    assign sampling     = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    assign active_trans = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign accept       = sampling && hsel && hready && active_trans;

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        hrdata_d  = hrdata_q;
        psel      = 1'b0;
        penable   = 1'b0;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WDATA: begin
                hreadyout = 1'b0;
                pwdata_d  = hwdata;
                state_d   = ST_SETUP;
            end
            ST_SETUP: begin
                hreadyout = 1'b0;
                psel      = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                hreadyout = 1'b0;
                psel      = 1'b1;
                penable   = 1'b1;
                if (pready) begin
                    if (pslverr) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_DONE;
                        if (!pwrite_q) begin
                            hrdata_d = prdata;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new address phase overrides the default return to IDLE in the sampling states.
        if (accept) begin
            paddr_d  = haddr;
            pwrite_d = hwrite;
            if (hsize > HSIZE_WORD) begin
                state_d = ST_ERR1;
            end else if (hwrite) begin
                state_d = ST_WDATA;
            end else begin
                state_d = ST_SETUP;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign paddr  = paddr_q;
    assign pwrite = pwrite_q;
    assign pwdata = pwdata_q;
    assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb2_apb_bridge.sv
// Directed bench for ahb2_apb_bridge: read, write with waits, slave error, bad size,
// back-to-back transfers, BUSY handling and mid-transfer reset.
module tb_ahb2_apb_bridge;
    import ahb2_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    ahb2_apb_bridge dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hrdata    (hrdata),
        .hresp     (hresp),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 hclk = ~hclk;

    // Advance to just after the next rising edge, where outputs are settled.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic apply_stimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                  input logic [2:0] size, input logic [31:0] addr);
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic e_psel, input logic e_pen,
                              input logic e_rdy, input logic [1:0] e_resp);
        check_output({tag, ".psel"},      {31'd0, psel},      {31'd0, e_psel});
        check_output({tag, ".penable"},   {31'd0, penable},   {31'd0, e_pen});
        check_output({tag, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, e_rdy});
        check_output({tag, ".hresp"},     {30'd0, hresp},     {30'd0, e_resp});
    endtask

    initial begin
        hreset  = 1'b1;
        hready  = 1'b1;
        hwdata  = 32'h0;
        prdata  = 32'h0;
        pready  = 1'b1;
        pslverr = 1'b0;
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        tick();
        tick();
        hreset = 1'b0;
        check_ctrl("reset", 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        check_output("reset.hrdata", hrdata, 32'h0);
        check_output("reset.paddr", paddr, 32'h0);
        check_output("reset.pwdata", pwdata, 32'h0);

        // Read, pready high in the first ACCESS cycle
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40);
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        prdata = 32'hDEADBEEF;
        pready = 1'b1;
        check_ctrl("rd.setup", 1'b1, 1'b0, 1'b0, HRESP_OKAY);
        check_output("rd.setup.paddr", paddr, 32'h40);
        check_output("rd.setup.pwrite", {31'd0, pwrite}, 32'd0);
        tick();
        check_ctrl("rd.access", 1'b1, 1'b1, 1'b0, HRESP_OKAY);
        tick();
        check_ctrl("rd.done", 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        check_output("rd.done.hrdata", hrdata, 32'hDEADBEEF);
        tick();

        // Write with two pready-low ACCESS cycles
        pready = 1'b0;
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h44);
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        hwdata = 32'h12345678;
        check_ctrl("wr.wdata", 1'b0, 1'b0, 1'b0, HRESP_OKAY);
        tick();
        hwdata = 32'hFFFF0000;
        check_ctrl("wr.setup", 1'b1, 1'b0, 1'b0, HRESP_OKAY);
        check_output("wr.setup.pwdata", pwdata, 32'h12345678);
        check_output("wr.setup.pwrite", {31'd0, pwrite}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) pready = 1'b1;
            check_ctrl($sformatf("wr.access%0d", i), 1'b1, 1'b1, 1'b0, HRESP_OKAY);
            check_output($sformatf("wr.access%0d.paddr", i), paddr, 32'h44);
            check_output($sformatf("wr.access%0d.pwdata", i), pwdata, 32'h12345678);
        end
        tick();
        check_ctrl("wr.done", 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        check_output("wr.done.hrdata", hrdata, 32'hDEADBEEF);
        tick();

        // Read answered with pslverr
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h48);
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        pslverr = 1'b1;
        prdata  = 32'hCAFEF00D;
        tick();
        check_ctrl("err.access", 1'b1, 1'b1, 1'b0, HRESP_OKAY);
        tick();
        pslverr = 1'b0;
        check_ctrl("err.err1", 1'b0, 1'b0, 1'b0, HRESP_ERROR);
        check_output("err.err1.hrdata", hrdata, 32'hDEADBEEF);
        tick();
        apply_stimulus(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        check_ctrl("err.err2", 1'b0, 1'b0, 1'b1, HRESP_ERROR);
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        check_ctrl("err.idle", 1'b0, 1'b0, 1'b1, HRESP_OKAY);

        // Unsupported transfer size
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, 3'b011, 32'h50);
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        check_ctrl("size.err1", 1'b0, 1'b0, 1'b0, HRESP_ERROR);
        tick();
        check_ctrl("size.err2", 1'b0, 1'b0, 1'b1, HRESP_ERROR);
        tick();
        check_ctrl("size.idle", 1'b0, 1'b0, 1'b1, HRESP_OKAY);

        // Back-to-back: read, read, write, then BUSY
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h60);
        prdata = 32'h0BADC0DE;
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        check_ctrl("b2b.a.setup", 1'b1, 1'b0, 1'b0, HRESP_OKAY);
        tick();
        check_ctrl("b2b.a.access", 1'b1, 1'b1, 1'b0, HRESP_OKAY);
        tick();
        check_ctrl("b2b.a.done", 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        check_output("b2b.a.hrdata", hrdata, 32'h0BADC0DE);
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h64);
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        check_ctrl("b2b.b.setup", 1'b1, 1'b0, 1'b0, HRESP_OKAY);
        check_output("b2b.b.paddr", paddr, 32'h64);
        prdata = 32'h13579BDF;
        tick();
        check_ctrl("b2b.b.access", 1'b1, 1'b1, 1'b0, HRESP_OKAY);
        tick();
        check_ctrl("b2b.b.done", 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        check_output("b2b.b.hrdata", hrdata, 32'h13579BDF);
        apply_stimulus(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h68);
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        hwdata = 32'hA5A55A5A;
        check_ctrl("b2b.c.wdata", 1'b0, 1'b0, 1'b0, HRESP_OKAY);
        tick();
        check_ctrl("b2b.c.setup", 1'b1, 1'b0, 1'b0, HRESP_OKAY);
        check_output("b2b.c.paddr", paddr, 32'h68);
        check_output("b2b.c.pwdata", pwdata, 32'hA5A55A5A);
        tick();
        check_ctrl("b2b.c.access", 1'b1, 1'b1, 1'b0, HRESP_OKAY);
        tick();
        check_ctrl("b2b.c.done", 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        check_output("b2b.c.hrdata", hrdata, 32'h13579BDF);
        apply_stimulus(1'b1, HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h6C);
        tick();
        check_ctrl("busy.0", 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        tick();
        check_ctrl("busy.1", 1'b0, 1'b0, 1'b1, HRESP_OKAY);

        // Reset while stalled in ACCESS
        pready = 1'b0;
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h70);
        tick();
        apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
        hwdata = 32'h55AA55AA;
        tick();
        tick();
        check_ctrl("rst.access", 1'b1, 1'b1, 1'b0, HRESP_OKAY);
        hreset = 1'b1;
        tick();
        check_ctrl("rst.0", 1'b0, 1'b0, 1'b1, HRESP_OKAY);
        check_output("rst.0.paddr", paddr, 32'h0);
        check_output("rst.0.pwdata", pwdata, 32'h0);
        check_output("rst.0.pwrite", {31'd0, pwrite}, 32'd0);
        check_output("rst.0.hrdata", hrdata, 32'h0);
        tick();
        hreset = 1'b0;
        pready = 1'b1;
        tick();
        check_ctrl("rst.after", 1'b0, 1'b0, 1'b1, HRESP_OKAY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
